// File: rtl/spram_reader.sv
// spram_reader: streaming read engine for a single-port RAM.
//
// On an accepted start, reads len consecutive words beginning at base (address wraps
// modulo DEPTH) and presents them on a valid/ready stream. The final word is flagged
// with m_last. A small FIFO absorbs the RAM read latency, so backpressure never drops
// or duplicates a word.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, base, len   command strobe (sampled only when idle), first address, word count
//   busy, done         command in progress / one-cycle completion pulse
//   mem_rd, mem_addr   RAM read strobe and address
//   mem_q              RAM read data, valid RD_LATENCY cycles after mem_rd
//   m_data, m_valid,   output stream; m_last marks the final word of the command
//   m_ready, m_last
//
// RD_LATENCY must be 0 (combinational RAM output) or 1 (registered RAM output).
module spram_reader #(
  parameter int unsigned DWIDTH     = 128,
  parameter int unsigned AWIDTH     = 2,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_q,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  // The FIFO holds one more word than the read pipeline can have in flight, so a
  // word per cycle is sustained while the head is being consumed.
  localparam int unsigned BufDepth = RD_LATENCY + 2;
  localparam int unsigned PtrW     = $clog2(BufDepth);
  localparam int unsigned CntW     = $clog2(BufDepth + 1);

  localparam logic [AWIDTH:0] DepthLen = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH:0]   remain_q, remain_d;

  logic [DWIDTH-1:0]   buf_data_q [BufDepth];
  logic [BufDepth-1:0] buf_last_q;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     cnt_q;

  logic            issue, issue_last;
  logic            push, push_last, pop;
  logic [CntW-1:0] inflight;
  logic [CntW:0]   occupancy;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credits are judged on start-of-cycle occupancy; a pop this cycle does not
  // enable a read until the next one.
  assign occupancy  = {1'b0, inflight} + {1'b0, cnt_q};
  assign issue      = (state_q == StRead) && (occupancy < (CntW + 1)'(BufDepth));
  assign issue_last = (remain_q == (AWIDTH + 1)'(1));
  assign pop        = m_valid && m_ready;

  // Return path: tags each read with its last flag and pushes mem_q exactly
  // RD_LATENCY cycles after the read was issued.
  if (RD_LATENCY == 0) begin : g_comb_ram
    assign push      = issue;
    assign push_last = issue_last;
    assign inflight  = '0;
  end else begin : g_reg_ram
    logic [RD_LATENCY-1:0] vld_q, lst_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        lst_q <= '0;
      end else begin
        vld_q[0] <= issue;
        lst_q[0] <= issue && issue_last;
        for (int i = 1; i < RD_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          lst_q[i] <= lst_q[i-1];
        end
      end
    end

    assign push      = vld_q[RD_LATENCY-1];
    assign push_last = lst_q[RD_LATENCY-1];
    assign inflight  = CntW'($countones(vld_q));
  end

  // Output FIFO. Storage is cleared on reset so m_data reads 0 afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BufDepth; i++) buf_data_q[i] <= '0;
      buf_last_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      if (push) begin
        buf_data_q[wptr_q] <= mem_q;
        buf_last_q[wptr_q] <= push_last;
        wptr_q             <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!push && pop) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d = base;
          // Illegal lengths above DEPTH clamp so the engine still terminates.
          remain_d = (len > DepthLen) ? DepthLen : len;
          state_d  = (len == '0) ? StFin : StRead;
        end
      end
      StRead: begin
        if (issue) begin
          addr_d   = addr_q + AWIDTH'(1);
          remain_d = remain_q - (AWIDTH + 1)'(1);
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_last) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin);
  assign mem_rd   = issue;
  assign mem_addr = addr_q;
  assign m_valid  = (cnt_q != '0);
  assign m_data   = buf_data_q[rptr_q];
  assign m_last   = m_valid && buf_last_q[rptr_q];

endmodule

// File: tb/tb_spram_reader.sv
// Self-checking bench for spram_reader: a registered-RAM instance checked against a
// queue-based model every cycle, plus a combinational-RAM instance with directed checks.
module tb_spram_reader;
  localparam int DW    = 128;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Registered-RAM instance
  logic          start1, busy1, done1, mem_rd1, m_valid1, m_ready1, m_last1;
  logic [AW-1:0] base1, mem_addr1;
  logic [AW:0]   len1;
  logic [DW-1:0] mem_q1 = '0;
  logic [DW-1:0] m_data1;

  // Combinational-RAM instance
  logic          start0, busy0, done0, mem_rd0, m_valid0, m_ready0, m_last0;
  logic [AW-1:0] base0, mem_addr0;
  logic [AW:0]   len0;
  logic [DW-1:0] mem_q0, m_data0;

  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h10);

  always @(posedge clk) if (mem_rd1) mem_q1 <= mem[mem_addr1];
  assign mem_q0 = mem[mem_addr0];

  spram_reader #(.DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .base(base1), .len(len1),
    .busy(busy1), .done(done1), .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_q(mem_q1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_last(m_last1)
  );

  spram_reader #(.DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .base(base0), .len(len0),
    .busy(busy0), .done(done0), .mem_rd(mem_rd0), .mem_addr(mem_addr0), .mem_q(mem_q0),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0), .m_last(m_last0)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: the expected address sequence and beat sequence of the current command.
  typedef struct packed {logic last; logic [DW-1:0] data;} beat_t;
  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] xfer_log[$];
  beat_t         cur_b;
  int            cmd_len = 0, cmd_issued = 0, xfer_cnt = 0, outstanding = 0;
  bit            hold_vld = 0, prev_done = 0;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  task automatic model_push(input int b, input int l);
    int n;
    n = (l > DEPTH) ? DEPTH : l;
    exp_q.delete();
    addr_q.delete();
    xfer_log.delete();
    for (int i = 0; i < n; i++) begin
      int a;
      a = (b + i) % DEPTH;
      addr_q.push_back(AW'(a));
      exp_q.push_back('{last: (i == n - 1), data: mem[a]});
    end
    cmd_len = n;
    cmd_issued = 0;
    xfer_cnt = 0;
    outstanding = 0;
  endtask

  task automatic model_flush();
    exp_q.delete();
    addr_q.delete();
    cmd_len = 0;
    cmd_issued = 0;
    outstanding = 0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld  = 0;
      prev_done = 0;
    end else begin
      if (hold_vld) begin
        chk("stall_valid", m_valid1, 1);
        chk("stall_data", m_data1, hold_data);
        chk("stall_last", m_last1, hold_last);
      end
      if (m_last1) chk("last_needs_valid", m_valid1, 1);
      if (mem_rd1) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_read", mem_rd1, 0);
        end else begin
          chk("rd_addr", mem_addr1, addr_q.pop_front());
          cmd_issued++;
          outstanding++;
        end
      end
      if (busy1) chk("outstanding_le3", outstanding > 3, 0);
      if (m_valid1 && m_ready1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", m_valid1, 0);
        end else begin
          cur_b = exp_q.pop_front();
          chk("beat_data", m_data1, cur_b.data);
          chk("beat_last", m_last1, cur_b.last);
          outstanding--;
          xfer_cnt++;
          xfer_log.push_back(m_data1);
        end
      end
      hold_vld  = m_valid1 && !m_ready1;
      hold_data = m_data1;
      hold_last = m_last1;
      if (done1) begin
        chk("done_single_cycle", prev_done, 0);
        chk("done_beats_left", exp_q.size(), 0);
        chk("done_read_count", cmd_issued, cmd_len);
      end
      prev_done = done1;
    end
  end

  task automatic cmd1(input int b, input int l, input bit accepted);
    @(posedge clk);
    #1;
    start1 = 1'b1;
    base1  = AW'(b);
    len1   = (AW + 1)'(l);
    if (accepted) model_push(b, l);
    @(posedge clk);
    #1 start1 = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done1) got = 1;
    end
    if (!got) chk("done_timeout", done1, 1);
  endtask

  logic          lg_busy [10], lg_done [10], lg_rd [10], lg_valid [10], lg_last [10];
  logic [AW-1:0] lg_addr [10];
  logic [DW-1:0] lg_data [10];

  task automatic log_cycles(input bit use0, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      lg_busy[k]  = use0 ? busy0 : busy1;
      lg_done[k]  = use0 ? done0 : done1;
      lg_rd[k]    = use0 ? mem_rd0 : mem_rd1;
      lg_addr[k]  = use0 ? mem_addr0 : mem_addr1;
      lg_valid[k] = use0 ? m_valid0 : m_valid1;
      lg_last[k]  = use0 ? m_last0 : m_last1;
      lg_data[k]  = use0 ? m_data0 : m_data1;
    end
  endtask

  bit pat [6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    rst_n = 1'b0;
    start1 = 0; base1 = 0; len1 = 0; m_ready1 = 1;
    start0 = 0; base0 = 0; len0 = 0; m_ready0 = 1;
    #3;
    chk("reset_busy", busy1, 0);
    chk("reset_done", done1, 0);
    chk("reset_mem_rd", mem_rd1, 0);
    chk("reset_m_valid", m_valid1, 0);
    chk("reset_m_last", m_last1, 0);
    chk("reset_mem_addr", mem_addr1, 0);
    chk("reset_m_data", m_data1, 0);
    chk("reset0_m_valid", m_valid0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Basic burst with literal cycle expectations.
    cmd1(0, 4, 1);
    log_cycles(0, 9);
    chk("basic_first_rd", lg_rd[1], 1);
    chk("basic_first_addr", lg_addr[1], 0);
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("basic_busy_c%0d", k), lg_busy[k], (k <= 7));
      chk($sformatf("basic_valid_c%0d", k), lg_valid[k], (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk($sformatf("basic_data_c%0d", k), lg_data[k], 'h10 + k - 3);
      chk($sformatf("basic_last_c%0d", k), lg_last[k], (k == 6));
      chk($sformatf("basic_done_c%0d", k), lg_done[k], (k == 7));
    end

    // Wrap-around.
    cmd1(3, 4, 1);
    wait_done(20);
    #1;
    chk("wrap_count", xfer_cnt, 4);
    if (xfer_log.size() == 4) begin
      chk("wrap_w0", xfer_log[0], 'h13);
      chk("wrap_w1", xfer_log[1], 'h10);
      chk("wrap_w3", xfer_log[3], 'h12);
    end

    // Backpressure, started the cycle after the previous done.
    cmd1(0, 4, 1);
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        m_ready1 = pat[i % 6];
        @(negedge clk);
        if (done1) got = 1;
        @(posedge clk);
        #1;
      end
      if (!got) chk("bp_done_timeout", done1, 1);
    end
    m_ready1 = 1'b1;
    chk("bp_count", xfer_cnt, 4);
    chk("bp_reads", cmd_issued, 4);
    if (xfer_log.size() == 4) begin
      chk("bp_w0", xfer_log[0], 'h10);
      chk("bp_w3", xfer_log[3], 'h13);
    end

    // Zero length.
    cmd1(1, 0, 1);
    log_cycles(0, 3);
    chk("zero_done_c1", lg_done[1], 1);
    chk("zero_busy_c1", lg_busy[1], 1);
    chk("zero_done_c2", lg_done[2], 0);
    chk("zero_busy_c2", lg_busy[2], 0);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("zero_rd_c%0d", k), lg_rd[k], 0);
      chk($sformatf("zero_valid_c%0d", k), lg_valid[k], 0);
    end

    // Start pulsed mid-burst must be ignored.
    cmd1(0, 4, 1);
    @(posedge clk);
    #1;
    start1 = 1'b1; base1 = 2; len1 = 4;
    @(posedge clk);
    #1 start1 = 1'b0;
    wait_done(20);
    #1;
    chk("ign_count", xfer_cnt, 4);
    if (xfer_log.size() == 4) begin
      chk("ign_w0", xfer_log[0], 'h10);
      chk("ign_w3", xfer_log[3], 'h13);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ign_idle_busy", busy1, 0);
      chk("ign_idle_rd", mem_rd1, 0);
    end

    // Illegal length saturates at DEPTH.
    cmd1(2, 7, 1);
    wait_done(30);
    #1;
    chk("sat_count", xfer_cnt, 4);
    if (xfer_log.size() == 4) chk("sat_w0", xfer_log[0], 'h12);

    // Combinational RAM instance.
    @(posedge clk);
    #1;
    start0 = 1'b1; base0 = 0; len0 = 4;
    @(posedge clk);
    #1 start0 = 1'b0;
    log_cycles(1, 7);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("comb_rd_c%0d", k), lg_rd[k], (k <= 4));
      if (k <= 4) chk($sformatf("comb_addr_c%0d", k), lg_addr[k], k - 1);
      chk($sformatf("comb_valid_c%0d", k), lg_valid[k], (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) chk($sformatf("comb_data_c%0d", k), lg_data[k], 'h10 + k - 2);
      chk($sformatf("comb_last_c%0d", k), lg_last[k], (k == 5));
      chk($sformatf("comb_done_c%0d", k), lg_done[k], (k == 6));
      chk($sformatf("comb_busy_c%0d", k), lg_busy[k], (k <= 6));
    end

    // Asynchronous reset after the second word is transferred.
    cmd1(0, 4, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (xfer_cnt >= 2) break;
    end
    chk("rst_progress", xfer_cnt >= 2, 1);
    chk("rst_pre_busy", busy1, 1);
    chk("rst_pre_valid", m_valid1, 1);
    #1 rst_n = 1'b0;
    model_flush();
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_mem_rd", mem_rd1, 0);
    chk("rst_m_valid", m_valid1, 0);
    chk("rst_m_last", m_last1, 0);
    chk("rst_mem_addr", mem_addr1, 0);
    chk("rst_m_data", m_data1, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cmd1(1, 2, 1);
    wait_done(20);
    #1;
    chk("post_rst_count", xfer_cnt, 2);
    if (xfer_log.size() == 2) begin
      chk("post_rst_w0", xfer_log[0], 'h11);
      chk("post_rst_w1", xfer_log[1], 'h12);
    end
    repeat (3) @(negedge clk);
    chk("post_rst_no_stale", m_valid1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_reader.md
# spram_reader

Streaming read engine for the single-port RAM primitive. On a `start` command it reads `len` consecutive words from a base address, wrapping modulo the RAM depth, and presents them on a valid/ready output stream with `m_last` on the final word. It absorbs the RAM read latency with an internal buffer, so downstream backpressure never drops or duplicates a word. It sits between a RAM instance (`mem_*` ports) and a streaming consumer such as a DMA or serializer.

## Interface
- `DWIDTH`, 128, data word width; must match the RAM.
- `AWIDTH`, 2, address width; RAM depth `DEPTH = 1 << AWIDTH`.
- `RD_LATENCY`, 1, RAM read latency in cycles:
  - 1 for a registered RAM output.
  - 0 for a combinational RAM output.
  - Other values are illegal.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base`  in  AWIDTH  first read address; captured with `start`.
- `len`  in  AWIDTH+1  word count, 0..DEPTH; captured with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high, inclusive.
- `done`  out  1  one-cycle pulse when the command completes.
- `mem_rd`  out  1  read strobe; the RAM owner must not write while it is high.
- `mem_addr`  out  AWIDTH  RAM read address.
- `mem_q`  in  DWIDTH  RAM read data; valid `RD_LATENCY` cycles after `mem_rd`.
- `m_data`  out  DWIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  qualifies the final word of the command.

## Operation
- **State machine:**
  - IDLE -> READ when `start` is high and `len` is nonzero.
  - IDLE -> FIN when `start` is high and `len` is 0.
  - READ -> DRAIN when the last read is issued.
  - DRAIN -> FIN when the `m_last` word is transferred (`m_valid && m_ready && m_last`).
  - FIN -> IDLE unconditionally; `done` is high only in FIN.
- `start` outside IDLE is ignored. No queuing, no error.
- **Reads:**
  - In READ, issue one read per cycle (`mem_rd=1`, `mem_addr=addr`) while `inflight + buf_count < RD_LATENCY+2`.
  - Occupancy is sampled at the start of the cycle; a same-cycle pop does not free a credit.
  - `addr` starts at `base` and increments modulo `DEPTH`. Wrap from DEPTH-1 to 0 is legal and silent.
  - `len = DEPTH` reads every location exactly once.
- **Return path:**
  - `mem_q` is written into the buffer exactly `RD_LATENCY` cycles after its `mem_rd`.
  - `inflight` is tracked by a shift register of length `RD_LATENCY`; with `RD_LATENCY=0` it is always 0.
- **Output buffer:**
  - FIFO of depth RD_LATENCY+2.
  - `m_valid` = buffer non-empty; `m_data` = head entry.
  - A pop occurs on `m_valid && m_ready`. Push and pop may occur in the same cycle.
  - Overflow cannot occur by construction; the bench asserts this.
- **`m_last`:** high exactly when the head word is word `len-1` of the command. A per-entry last flag is stored alongside the data.
- **Widths:**
  - The remaining-issue counter is AWIDTH+1 bits.
  - `len` values above DEPTH are illegal. Behaviour on them is undefined, but the engine must not hang; it saturates at DEPTH.
- **Reset** (async, any state, including mid-burst):
  - State returns to IDLE; the buffer and in-flight pipeline are flushed; partial data is discarded.
  - Outputs `busy`, `done`, `mem_rd`, `m_valid`, `m_last` go to 0; `mem_addr` and `m_data` go to 0.

## Timing
- `start` sampled high at edge E0 (cycle 0):
  - `busy=1` from cycle 1.
  - First `mem_rd` with `mem_addr=base` in cycle 1.
- First `m_valid`:
  - `RD_LATENCY=1`: cycle 3.
  - `RD_LATENCY=0`: cycle 2.
- With `m_ready` held high the engine sustains one word per cycle. `len=N` yields `m_last` in cycle N+2 and `done` in cycle N+3 (`RD_LATENCY=1`).
- `len=0`: `done` and `busy` both high in cycle 1. No `mem_rd`, no stream beats.
- `m_ready` low: `m_data`, `m_valid` and `m_last` hold stable. Reads stop once credits are exhausted and resume the cycle after a pop frees a credit.
- `done` is high for exactly one cycle. The next `start` can be accepted in the cycle after `done`.

## Test plan
- **Basic burst:** RAM preloaded with `mem[i]=i+0x10`, `RD_LATENCY=1`, `base=0`, `len=4`, `m_ready=1`.
  - Expect data 0x10..0x13 in cycles 3..6, `m_last` only in cycle 6, `done` in cycle 7, `busy` in cycles 1..7.
- **Wrap-around:** `base=3`, `len=4`, `AWIDTH=2`.
  - Expect address sequence 3,0,1,2 and data 0x13,0x10,0x11,0x12.
- **Backpressure:** `m_ready` toggled 1,0,0,1,0,1... over `len=4`.
  - Expect all 4 words exactly once, in order, with data stable while stalled.
  - Expect `mem_rd` count=4 and at most 3 outstanding words at any time.
- **Zero length and ignored start:** `len=0`.
  - Expect `done` in cycle 1 and no `mem_rd`.
  - During a `len=4` burst, pulse `start` with `base=2`: expect it ignored and output unchanged.
- **Combinational RAM:** `RD_LATENCY=0`, `len=4`, `m_ready=1`.
  - Expect first `m_valid` in cycle 2, then 4 back-to-back words.
- **Reset mid-burst:** assert `rst_n=0` asynchronously after the second word is transferred.
  - Expect all outputs 0 immediately.
  - After release, a new `start` (`base=1`, `len=2`) yields exactly 0x11,0x12 with no stale words.
